// File: rtl/cpu_cu_pkg.sv
// Shared types and constants for the 16-bit RISC sequencing control unit:
// FSM states, instruction classes, opcodes, branch conditions and IR field positions.
package cpu_cu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } cuStateT;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_JR,
        CLS_HALT,
        CLS_ILLEGAL
    } instrClassT;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ST   = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [3:0] COND_ALWAYS = 4'b0000;
    localparam logic [3:0] COND_Z      = 4'b0001;
    localparam logic [3:0] COND_NZ     = 4'b0010;
    localparam logic [3:0] COND_N      = 4'b0011;
    localparam logic [3:0] COND_C      = 4'b0100;

    localparam int IR_ALU_BIT  = 15;
    localparam int IR_OPC_HI   = 14;
    localparam int IR_OPC_LO   = 12;
    localparam int IR_ALUOP_HI = 14;
    localparam int IR_ALUOP_LO = 11;
    localparam int IR_RD_HI    = 10;
    localparam int IR_RD_LO    = 8;
    localparam int IR_RS_HI    = 5;
    localparam int IR_RS_LO    = 3;
    localparam int IR_RT_HI    = 2;
    localparam int IR_RT_LO    = 0;
    localparam int IR_COND_HI  = 11;
    localparam int IR_COND_LO  = 8;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } flagsT;

    // Undefined condition codes never branch.
    function automatic logic condTrue(input logic [3:0] cond, input flagsT f);
        case (cond)
            COND_ALWAYS: condTrue = 1'b1;
            COND_Z:      condTrue = f.z;
            COND_NZ:     condTrue = ~f.z;
            COND_N:      condTrue = f.n;
            COND_C:      condTrue = f.c;
            default:     condTrue = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: IR -> instruction class, ALU opcode,
// register fields and branch condition.
module cu_decoder
    import cpu_cu_pkg::*;
(
    input  logic [15:0] i_ir,
    output instrClassT  o_class,
    output logic [3:0]  o_aluOp,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rs,
    output logic [2:0]  o_rt,
    output logic [3:0]  o_cond
);

    // The branch offset bits are consumed by the EU adder, not by the sequencer.
    logic w_unusedOffset;
    assign w_unusedOffset = &{1'b0, i_ir[7:6]};

    assign o_aluOp = i_ir[IR_ALUOP_HI:IR_ALUOP_LO];
    assign o_rd    = i_ir[IR_RD_HI:IR_RD_LO];
    assign o_rs    = i_ir[IR_RS_HI:IR_RS_LO];
    assign o_rt    = i_ir[IR_RT_HI:IR_RT_LO];
    assign o_cond  = i_ir[IR_COND_HI:IR_COND_LO];

    always_comb begin
        o_class = CLS_ILLEGAL;
        if (i_ir[IR_ALU_BIT]) begin
            o_class = CLS_ALU;
        end else begin
            case (i_ir[IR_OPC_HI:IR_OPC_LO])
                OP_NOP:  o_class = CLS_NOP;
                OP_LD:   o_class = CLS_LD;
                OP_ST:   o_class = CLS_ST;
                OP_BR:   o_class = CLS_BR;
                OP_JR:   o_class = CLS_JR;
                OP_HALT: o_class = CLS_HALT;
                default: o_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC|MEM sequencer for the 16-bit RISC execution unit.
// Define CPU_CU_MEM_WAIT_EN to add the mem_rdy port and memory wait states.
module cpu_control_unit
    import cpu_cu_pkg::*;
#(
    parameter logic [3:0] ALU_PASS_OP = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR_in,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
`ifdef CPU_CU_MEM_WAIT_EN
    input  logic        mem_rdy,
`endif
    output logic        W_en,
    output logic        S_Sel,
    output logic        Adr_Sel,
    output logic        PC_ld,
    output logic        PC_inc,
    output logic        PC_sel,
    output logic        IR_ld,
    output logic [3:0]  ALU_OP,
    output logic [2:0]  W_adr,
    output logic [2:0]  R_adr,
    output logic [2:0]  S_adr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        illegal
);

    cuStateT    r_state;
    cuStateT    w_nextState;
    flagsT      r_flags;
    logic       r_illegal;
    logic       w_memRdy;
    logic       w_latchFlags;
    logic       w_setIllegal;
    logic       w_brTaken;
    instrClassT w_class;
    logic [3:0] w_aluOp;
    logic [2:0] w_rd;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [3:0] w_cond;

`ifdef CPU_CU_MEM_WAIT_EN
    assign w_memRdy = mem_rdy;
`else
    assign w_memRdy = 1'b1;
`endif

    cu_decoder u_decoder (
        .i_ir    (IR_in),
        .o_class (w_class),
        .o_aluOp (w_aluOp),
        .o_rd    (w_rd),
        .o_rs    (w_rs),
        .o_rt    (w_rt),
        .o_cond  (w_cond)
    );

    assign w_latchFlags = (r_state == EXEC) && (w_class == CLS_ALU);
    assign w_setIllegal = (r_state == DECODE) && (w_class == CLS_ILLEGAL);
    assign w_brTaken    = condTrue(w_cond, r_flags);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_latchFlags) begin
                r_flags <= '{n: N, z: Z, c: C};
            end
            if (w_setIllegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Everything stays at its idle value while reset is low, so an abandoned
    // instruction can never leave a partial register or memory write behind.
    always_comb begin
        w_nextState = r_state;
        W_en        = 1'b0;
        S_Sel       = 1'b0;
        Adr_Sel     = 1'b0;
        PC_ld       = 1'b0;
        PC_inc      = 1'b0;
        PC_sel      = 1'b0;
        IR_ld       = 1'b0;
        ALU_OP      = ALU_PASS_OP;
        W_adr       = 3'd0;
        R_adr       = 3'd0;
        S_adr       = 3'd0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            illegal = r_illegal;
            case (r_state)
                FETCH: begin
                    mem_rd = 1'b1;
                    IR_ld  = w_memRdy;
                    PC_inc = w_memRdy;
                    if (w_memRdy) begin
                        w_nextState = DECODE;
                    end
                end
                DECODE: begin
                    case (w_class)
                        CLS_LD, CLS_ST:        w_nextState = MEM;
                        CLS_HALT, CLS_ILLEGAL: w_nextState = HALT;
                        default:               w_nextState = EXEC;
                    endcase
                end
                EXEC: begin
                    w_nextState = FETCH;
                    case (w_class)
                        CLS_ALU: begin
                            W_en   = 1'b1;
                            ALU_OP = w_aluOp;
                            W_adr  = w_rd;
                            R_adr  = w_rs;
                            S_adr  = w_rt;
                        end
                        CLS_BR: begin
                            PC_ld = w_brTaken;
                        end
                        CLS_JR: begin
                            S_adr  = w_rt;
                            PC_sel = 1'b1;
                            PC_ld  = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                MEM: begin
                    Adr_Sel = 1'b1;
                    R_adr   = w_rs;
                    if (w_class == CLS_LD) begin
                        mem_rd = 1'b1;
                        S_Sel  = 1'b1;
                        W_en   = w_memRdy;
                        W_adr  = w_rd;
                    end else if (w_class == CLS_ST) begin
                        mem_wr = 1'b1;
                        S_adr  = w_rt;
                    end
                    if (w_memRdy) begin
                        w_nextState = FETCH;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_nextState = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: per-cycle expected control vectors are
// queued by the stimulus process and compared by a negedge monitor.
module tb_cpu_control_unit;

    localparam logic [3:0] PASS = 4'hA;

    typedef struct packed {
        logic       wEn;
        logic       sSel;
        logic       adrSel;
        logic       pcLd;
        logic       pcInc;
        logic       pcSel;
        logic       irLd;
        logic       memRd;
        logic       memWr;
        logic       halted;
        logic       illegal;
        logic [3:0] aluOp;
        logic [2:0] wAdr;
        logic [2:0] rAdr;
        logic [2:0] sAdr;
    } ctrlT;

    typedef struct {
        string name;
        ctrlT  exp;
    } sbEntryT;

    logic        clk;
    logic        reset;
    logic [15:0] IR_in;
    logic        N, Z, C;
    logic        mem_rdy;
    logic        W_en, S_Sel, Adr_Sel, PC_ld, PC_inc, PC_sel, IR_ld;
    logic [3:0]  ALU_OP;
    logic [2:0]  W_adr, R_adr, S_adr;
    logic        mem_rd, mem_wr, halted, illegal;

    sbEntryT expQ[$];
    int      total = 0;
    int      bad   = 0;

    cpu_control_unit #(.ALU_PASS_OP(PASS)) dut (
        .clk     (clk),
        .reset   (reset),
        .IR_in   (IR_in),
        .N       (N),
        .Z       (Z),
        .C       (C),
`ifdef CPU_CU_MEM_WAIT_EN
        .mem_rdy (mem_rdy),
`endif
        .W_en    (W_en),
        .S_Sel   (S_Sel),
        .Adr_Sel (Adr_Sel),
        .PC_ld   (PC_ld),
        .PC_inc  (PC_inc),
        .PC_sel  (PC_sel),
        .IR_ld   (IR_ld),
        .ALU_OP  (ALU_OP),
        .W_adr   (W_adr),
        .R_adr   (R_adr),
        .S_adr   (S_adr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrlT expIdle();
        ctrlT e;
        e = '0;
        e.aluOp = PASS;
        return e;
    endfunction

    function automatic ctrlT expFetch();
        ctrlT e;
        e = expIdle();
        e.memRd = 1'b1;
        e.irLd  = 1'b1;
        e.pcInc = 1'b1;
        return e;
    endfunction

    function automatic ctrlT expAlu(input logic [3:0] op, input logic [2:0] w, input logic [2:0] r, input logic [2:0] s);
        ctrlT e;
        e = expIdle();
        e.wEn   = 1'b1;
        e.aluOp = op;
        e.wAdr  = w;
        e.rAdr  = r;
        e.sAdr  = s;
        return e;
    endfunction

    function automatic ctrlT expBr(input logic taken);
        ctrlT e;
        e = expIdle();
        e.pcLd = taken;
        return e;
    endfunction

    function automatic ctrlT expJr(input logic [2:0] s);
        ctrlT e;
        e = expIdle();
        e.pcLd  = 1'b1;
        e.pcSel = 1'b1;
        e.sAdr  = s;
        return e;
    endfunction

    function automatic ctrlT expLd(input logic [2:0] w, input logic [2:0] r);
        ctrlT e;
        e = expIdle();
        e.adrSel = 1'b1;
        e.rAdr   = r;
        e.memRd  = 1'b1;
        e.sSel   = 1'b1;
        e.wEn    = 1'b1;
        e.wAdr   = w;
        return e;
    endfunction

    function automatic ctrlT expSt(input logic [2:0] r, input logic [2:0] s);
        ctrlT e;
        e = expIdle();
        e.adrSel = 1'b1;
        e.rAdr   = r;
        e.memWr  = 1'b1;
        e.sAdr   = s;
        return e;
    endfunction

    function automatic ctrlT expHalt(input logic ill);
        ctrlT e;
        e = expIdle();
        e.halted  = 1'b1;
        e.illegal = ill;
        return e;
    endfunction

    // One clock cycle of stimulus plus the control vector expected during it.
    task automatic applyStimulus(input string name, input logic rst, input logic [15:0] ir,
                                 input logic [2:0] nzc, input logic rdy, input ctrlT exp);
        sbEntryT ent;
        @(posedge clk);
        #1;
        reset   = rst;
        IR_in   = ir;
        {N, Z, C} = nzc;
        mem_rdy = rdy;
        ent.name = name;
        ent.exp  = exp;
        expQ.push_back(ent);
    endtask

    task automatic runInstr(input string name, input logic [15:0] ir, input logic [2:0] nzc, input ctrlT exp3);
        applyStimulus({name, "/fetch"},  1'b1, ir, nzc, 1'b1, expFetch());
        applyStimulus({name, "/decode"}, 1'b1, ir, nzc, 1'b1, expIdle());
        applyStimulus({name, "/exec"},   1'b1, ir, nzc, 1'b1, exp3);
    endtask

    task automatic checkOutput(input sbEntryT ent);
        ctrlT act;
        act = '{wEn: W_en, sSel: S_Sel, adrSel: Adr_Sel, pcLd: PC_ld, pcInc: PC_inc,
                pcSel: PC_sel, irLd: IR_ld, memRd: mem_rd, memWr: mem_wr, halted: halted,
                illegal: illegal, aluOp: ALU_OP, wAdr: W_adr, rAdr: R_adr, sAdr: S_adr};
        total++;
        if (act !== ent.exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", ent.name, act, ent.exp);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin : stim
        reset   = 1'b0;
        IR_in   = 16'h0000;
        {N, Z, C} = 3'b000;
        mem_rdy = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset_hold", 1'b0, 16'h8A53, 3'b111, 1'b1, expIdle());
        end

        runInstr("alu_z",       16'h8A53, 3'b010, expAlu(4'h1, 3'd2, 3'd2, 3'd3));
        runInstr("br_z_taken",  16'h31FE, 3'b000, expBr(1'b1));
        runInstr("alu_clr",     16'h8A53, 3'b000, expAlu(4'h1, 3'd2, 3'd2, 3'd3));
        runInstr("br_z_not",    16'h31FE, 3'b111, expBr(1'b0));
        runInstr("br_nz_taken", 16'h32FE, 3'b000, expBr(1'b1));
        runInstr("ld",          16'h1318, 3'b111, expLd(3'd3, 3'd3));
        runInstr("st",          16'h201A, 3'b111, expSt(3'd3, 3'd2));
        runInstr("jr",          16'h4005, 3'b111, expJr(3'd5));
        runInstr("nop",         16'h0000, 3'b111, expIdle());
        runInstr("br_nz_kept",  16'h32FE, 3'b111, expBr(1'b1));

        // N=1, Z=0, C=1 latched, then every condition code exercised against it.
        runInstr("alu_nc",      16'hF4C7, 3'b101, expAlu(4'hE, 3'd4, 3'd0, 3'd7));
        runInstr("br_n",        16'h33FE, 3'b000, expBr(1'b1));
        runInstr("br_c",        16'h34FE, 3'b000, expBr(1'b1));
        runInstr("br_z_clear",  16'h31FE, 3'b111, expBr(1'b0));
        runInstr("br_always",   16'h3080, 3'b000, expBr(1'b1));
        runInstr("br_cond5",    16'h357F, 3'b111, expBr(1'b0));
        runInstr("br_cond15",   16'h3F00, 3'b111, expBr(1'b0));

        applyStimulus("ld_abort/fetch",  1'b1, 16'h1318, 3'b000, 1'b1, expFetch());
        applyStimulus("ld_abort/decode", 1'b1, 16'h1318, 3'b000, 1'b1, expIdle());
        applyStimulus("ld_abort/reset",  1'b0, 16'h1318, 3'b000, 1'b1, expIdle());
        runInstr("br_n_flags_cleared",   16'h33FE, 3'b111, expBr(1'b0));
        runInstr("br_nz_flags_cleared",  16'h32FE, 3'b111, expBr(1'b1));

        applyStimulus("halt/fetch",  1'b1, 16'h5000, 3'b000, 1'b1, expFetch());
        applyStimulus("halt/decode", 1'b1, 16'h5000, 3'b000, 1'b1, expIdle());
        for (int i = 0; i < 2; i++) begin
            applyStimulus("halt/stay", 1'b1, 16'h8A53, 3'b111, 1'b1, expHalt(1'b0));
        end
        applyStimulus("halt/reset", 1'b0, 16'h6000, 3'b000, 1'b1, expIdle());

        applyStimulus("illegal/fetch",  1'b1, 16'h6000, 3'b000, 1'b1, expFetch());
        applyStimulus("illegal/decode", 1'b1, 16'h6000, 3'b000, 1'b1, expIdle());
        for (int i = 0; i < 3; i++) begin
            applyStimulus("illegal/stay", 1'b1, 16'h8A53, 3'b111, 1'b1, expHalt(1'b1));
        end
        applyStimulus("illegal/reset", 1'b0, 16'h1318, 3'b000, 1'b1, expIdle());

`ifdef CPU_CU_MEM_WAIT_EN
        begin : waitTest
            ctrlT fetchWait;
            ctrlT ldWait;
            fetchWait = expFetch();
            fetchWait.irLd  = 1'b0;
            fetchWait.pcInc = 1'b0;
            ldWait = expLd(3'd3, 3'd3);
            ldWait.wEn = 1'b0;
            for (int i = 0; i < 4; i++) begin
                applyStimulus("fetch_wait", 1'b1, 16'h1318, 3'b000, 1'b0, fetchWait);
            end
            applyStimulus("fetch_rdy", 1'b1, 16'h1318, 3'b000, 1'b1, expFetch());
            applyStimulus("ld_decode", 1'b1, 16'h1318, 3'b000, 1'b1, expIdle());
            for (int i = 0; i < 2; i++) begin
                applyStimulus("ld_wait", 1'b1, 16'h1318, 3'b000, 1'b0, ldWait);
            end
            applyStimulus("ld_rdy",    1'b1, 16'h1318, 3'b000, 1'b1, expLd(3'd3, 3'd3));
            applyStimulus("st_fetch",  1'b1, 16'h201A, 3'b000, 1'b1, expFetch());
            applyStimulus("st_decode", 1'b1, 16'h201A, 3'b000, 1'b1, expIdle());
            applyStimulus("st_wait",   1'b1, 16'h201A, 3'b000, 1'b0, expSt(3'd3, 3'd2));
            applyStimulus("st_rdy",    1'b1, 16'h201A, 3'b000, 1'b1, expSt(3'd3, 3'd2));
            applyStimulus("next_fetch", 1'b1, 16'h0000, 3'b000, 1'b1, expFetch());
        end
`else
        runInstr("ld_after_reset", 16'h1318, 3'b000, expLd(3'd3, 3'd3));
`endif

        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Sequencing control unit for the 16-bit RISC CPU, driving the control inputs of the execution unit. It consumes the instruction register contents and the N/Z/C flags, and produces the following:
- register-file, PC and IR control strobes;
- the ALU opcode;
- memory read/write strobes.

It runs a multi-cycle fetch/decode/execute state machine and keeps a latched copy of the status flags for conditional branches.

## Interface
- `ALU_PASS_OP`, default `4'h0`: ALU_OP encoding that passes the S operand to D_out unchanged. It must match the datapath ALU encoding.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `IR_in` in 16: instruction register contents (EU IR_out).
- `N`, `Z`, `C` in 1 each: ALU flags from the datapath, valid combinationally for the current ALU_OP and operands.
- `mem_rdy` in 1: memory ready. Present only with `CPU_CU_MEM_WAIT_EN`.
- `W_en`, `S_Sel`, `Adr_Sel`, `PC_ld`, `PC_inc`, `PC_sel`, `IR_ld` out 1 each: EU control strobes.
- `ALU_OP` out 4: ALU operation.
- `W_adr`, `R_adr`, `S_adr` out 3 each: register-file write and read addresses.
- `mem_rd`, `mem_wr` out 1 each: memory read and write strobes. The address is EU Address_data; write data is EU D_out.
- `halted` out 1: CPU stopped.
- `illegal` out 1: sticky, set when an undefined opcode was decoded.

## Operation
**Instruction format.** If `IR[15]`=1, the instruction is an ALU op:
- `ALU_OP`=IR[14:11]
- `W_adr`=IR[10:8]
- `R_adr`=IR[5:3]
- `S_adr`=IR[2:0]

If `IR[15]`=0, IR[14:12] is the opcode:
- `000` NOP.
- `001` LD: Rd=IR[10:8] ← mem[R(IR[5:3])].
- `010` ST: mem[R(IR[5:3])] ← R(IR[2:0]).
- `011` BR: cond=IR[11:8] (`0000` always, `0001` Z, `0010` !Z, `0011` N, `0100` C, others never); offset=IR[7:0].
- `100` JR: PC ← R(IR[2:0]).
- `101` HALT.
- `110`, `111` illegal.

**States.**
- FETCH: `Adr_Sel`=0, `mem_rd`=1, `IR_ld`=1, `PC_inc`=1. Next state is DECODE.
- DECODE: no strobes. Next state depends on the opcode:
  - ALU, BR, JR, NOP go to EXEC.
  - LD, ST go to MEM.
  - HALT goes to HALT.
  - illegal sets `illegal` and goes to HALT.
- EXEC:
  - ALU: `W_en`=1, `S_Sel`=0; latch N/Z/C into the flag register.
  - BR taken (tested against the latched flags): `PC_sel`=0, `PC_ld`=1, giving PC ← PC+sext(IR[7:0]). PC already points past the branch, so the offset is relative to the next instruction.
  - JR: `ALU_OP`=`ALU_PASS_OP`, `S_adr`=IR[2:0], `PC_sel`=1, `PC_ld`=1.
  - Next state is FETCH.
- MEM: `Adr_Sel`=1, `R_adr`=IR[5:3].
  - LD: `mem_rd`=1, `S_Sel`=1, `W_en`=1, `W_adr`=IR[10:8].
  - ST: `mem_wr`=1, `ALU_OP`=`ALU_PASS_OP`, `S_adr`=IR[2:0].
  - Next state is FETCH.
- HALT: all strobes 0, `halted`=1. Left only by reset.

**Flags and arithmetic.**
- The flag register is written only in ALU EXEC. LD, ST and JR leave it unchanged.
- PC arithmetic wraps modulo 2^16 in the EU. Branch range is −128..+127.

**Outputs.**
- Outputs are a function of state and IR_in. Unused address fields are 0.
- `ALU_OP` defaults to `ALU_PASS_OP` when no ALU operation is required.

## Timing
- **Reset.** While `reset`=0, all strobes are forced to 0 combinationally, along with `ALU_OP`=`ALU_PASS_OP`, all addresses 0, `halted`=0 and `illegal`=0.
- **After reset.** The state is FETCH on the first edge with `reset`=1. Reset mid-instruction abandons the instruction with no partial write. The flag register clears to 0.
- **Latency.** Every instruction takes 3 cycles: FETCH, DECODE, EXEC/MEM. HALT and illegal take 2 cycles to reach HALT.
- **Write timing.** Register writes and PC/IR loads take effect at the rising edge ending the strobe cycle.
- **Memory timing.** Without wait states, memory returns D_in combinationally in the same cycle as `mem_rd`.

## Configuration
`CPU_CU_MEM_WAIT_EN` controls memory wait states.
- **Defined:**
  - The `mem_rdy` port exists.
  - FETCH and MEM hold their state and keep `mem_rd`/`mem_wr`/`Adr_Sel` asserted until `mem_rdy`=1.
  - `IR_ld`, `PC_inc` and the LD `W_en` are asserted only in the cycle with `mem_rdy`=1.
  - A ST completes in the `mem_rdy` cycle.
  - Reset during a wait aborts it.
- **Undefined:** the port is absent and memory is always single-cycle.

## Structure
- Package `cpu_cu_pkg` holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, HALT);
  - the opcode constants;
  - the condition codes;
  - the instruction field bit positions.
- One sub-module, `cu_decoder`: combinational IR → instruction class, register fields and condition. The FSM, flag register and output logic stay in the top.

## Test plan
- **Reset release:** hold `reset`=0 for 3 cycles, then release. Cycle 1 is FETCH with `mem_rd`=`IR_ld`=`PC_inc`=1; no strobes are asserted during reset.
- **ALU op:** IR=16'h8A53 with N/Z/C=0,1,0 at EXEC. Expect `ALU_OP`=4'h1, `W_adr`=2, `R_adr`=2, `S_adr`=3, `W_en`=1 for exactly one cycle; the latched Z=1.
- **Conditional branch:** BR Z (16'h31FE) after the ALU op above sets Z=1. Expect `PC_ld`=1, `PC_sel`=0 in EXEC. After a clearing ALU op, the same BR gives `PC_ld`=0.
- **LD/ST:** LD 16'h1318 produces MEM with `Adr_Sel`=1, `R_adr`=3, `S_Sel`=1, `W_en`=1, `W_adr`=3. ST 16'h201A produces `mem_wr`=1, `S_adr`=2, `W_en`=0.
- **Illegal opcode:** IR=16'h6000 sets `illegal` and `halted` after 2 cycles; both stay high and every strobe stays 0 until reset.
- **Wait states** (`CPU_CU_MEM_WAIT_EN`): hold `mem_rdy`=0 for 4 cycles in FETCH. The state holds with `IR_ld`=0; `IR_ld`=`PC_inc`=1 only in the `mem_rdy` cycle.
